// File: rtl/gb_apu_wave_ram.sv
// Game Boy APU channel-3 wave RAM: 16 bytes shared between the CPU
// (0xFF30..0xFF3F) and the wave channel's sample fetcher.
// While the channel plays, the CPU only reaches the byte the channel last
// fetched, and only for a short window after that fetch. Outside the window,
// writes are dropped and reads return 0xFF.
module gb_apu_wave_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_wr,
   input  logic              cpu_rd,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ch_on,
   input  logic [ADDR_W-1:0] ch_addr,
   input  logic              ch_fetch,
   output logic [DATA_W-1:0] wave_data,
   output logic              window
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [DATA_W-1:0] LOCKED_RD = {DATA_W{1'b1}};
   localparam logic [1:0] WIN_LOAD = 2'd2;

   // Window counter steps down and sticks at zero.
   function automatic logic [1:0] sat_dec(input logic [1:0] v);
      return (v == 2'd0) ? 2'd0 : v - 2'd1;
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];
   logic [1:0]        win_cnt_p1;
   logic [ADDR_W-1:0] last_addr_p1;

   logic              win_open;
   logic              cpu_ok;
   logic [ADDR_W-1:0] acc_addr;
   logic              wr_en;

   // Access arbitration uses only pre-edge state, so a fetch in the same
   // cycle never changes what the CPU is allowed to touch this cycle.
   always_comb begin
      win_open = (win_cnt_p1 != 2'd0);
      window   = win_open & ch_on;
      cpu_ok   = ~ch_on | win_open;
      acc_addr = ch_on ? last_addr_p1 : cpu_addr;
      wr_en    = cpu_wr & cpu_ok;
   end

   // Storage: CPU writes land on the arbitrated byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[acc_addr] <= cpu_wdata;
      end
   end

   // CPU read port: registered, holds when idle, 0xFF when locked out.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_rdata <= LOCKED_RD;
      end else if (cpu_rd) begin
         cpu_rdata <= cpu_ok ? mem[acc_addr] : LOCKED_RD;
      end
   end

   // Channel fetch port: captures the byte as it was before this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         wave_data <= '0;
      end else if (ch_fetch) begin
         wave_data <= mem[ch_addr];
      end
   end

   // Fetch bookkeeping: remember the fetched byte and open the window.
   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt_p1   <= 2'd0;
         last_addr_p1 <= '0;
      end else if (ch_fetch) begin
         win_cnt_p1   <= WIN_LOAD;
         last_addr_p1 <= ch_addr;
      end else begin
         win_cnt_p1   <= sat_dec(win_cnt_p1);
      end
   end

endmodule

// File: doc/gb_apu_wave_ram.md
GB_APU_WAVE_RAM -- requirements
Module: gb_apu_wave_ram

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_addr  input  4  wave RAM byte index (0xFF30 + cpu_addr).
REQ-005 cpu_wr  input  1  CPU write strobe, one cycle per access.
REQ-006 cpu_rd  input  1  CPU read strobe, one cycle per access.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_rdata  output  8  CPU read data, registered.
REQ-009 ch_on  input  1  channel 3 active: CPU access is restricted while it is high.
REQ-010 ch_addr  input  4  channel byte pointer, equal to nibble pointer[4:1].
REQ-011 ch_fetch  input  1  one-cycle pulse: the channel requests byte ch_addr.
REQ-012 wave_data  output  8  byte last fetched for the channel, registered.
REQ-013 window  output  1  high while the CPU may access wave RAM during ch_on.

Function
REQ-014 Storage SHALL be 16 x 8-bit registers, mem[0..15].
REQ-015 On ch_fetch, the next cycle SHALL have wave_data = mem[ch_addr] (pre-write value) and last_addr = ch_addr: 1-cycle latency.
REQ-016 ch_fetch SHALL be accepted regardless of ch_on.
REQ-017 The 2-bit window counter SHALL load 2 on ch_fetch and otherwise decrement to 0, saturating.
REQ-018 The window output SHALL equal (counter != 0) AND ch_on: high for exactly the 2 cycles after a fetch while the channel is on.
REQ-019 With ch_on low, cpu_wr SHALL write mem[cpu_addr] <= cpu_wdata at that clock edge.
REQ-020 With ch_on low, cpu_rd SHALL give cpu_rdata = mem[cpu_addr] the next cycle.
REQ-021 With ch_on high and window high, cpu_wr SHALL write mem[last_addr]; cpu_addr is ignored.
REQ-022 With ch_on high and window high, cpu_rd SHALL return mem[last_addr]; cpu_addr is ignored.
REQ-023 With ch_on high and window low, cpu_wr SHALL be dropped with no state change.
REQ-024 With ch_on high and window low, cpu_rd SHALL return 0xFF.
REQ-025 cpu_rdata SHALL hold its value when cpu_rd is low.
REQ-026 Simultaneous cpu_rd and cpu_wr to the same byte SHALL make the read return the old value.
REQ-027 Simultaneous ch_fetch and an allowed cpu_wr to the same byte SHALL make wave_data capture the old value; the memory takes the new value.
REQ-028 During a ch_fetch cycle, access permission SHALL use the pre-fetch window and last_addr.
REQ-029 When ch_on falls, CPU access SHALL become unrestricted on the same cycle; the counter continues decrementing.
REQ-030 Pointer wrap from 15 to 0 SHALL need no special handling: ch_addr is used as given.
REQ-031 Combined update order within a cycle SHALL be: reads sample the old state, then writes/fetch/counter commit.

Reset
REQ-032 Reset SHALL set mem[0..15] = 0x00, wave_data = 0x00, cpu_rdata = 0xFF, counter = 0, last_addr = 0, window = 0.
REQ-033 Reset SHALL take priority over all strobes in the same cycle.
REQ-034 Reset mid-window SHALL drop window the next cycle and lose any pending access.

Verification
REQ-035 Unrestricted access: ch_on=0, write 0xA5 to idx 3, then read idx 3 -> cpu_rdata=0xA5 one cycle after cpu_rd.
REQ-036 Fetch: mem[7]=0x3C, ch_fetch with ch_addr=7 -> next cycle wave_data=0x3C, window=1 for 2 cycles, then 0.
REQ-037 Locked access: ch_on=1, window=0, write 0x11 to idx 2, then read idx 2 -> read=0xFF and mem[2] unchanged.
REQ-038 Window redirect: ch_on=1, fetch idx 5, then in the next cycle write 0x99 with cpu_addr=0 -> mem[5]=0x99, mem[0] unchanged; reading idx 9 in the window -> 0x99.
REQ-039 Collision: allowed cpu_wr 0x77 to last_addr=4 together with ch_fetch ch_addr=4 (old value 0x12) -> wave_data=0x12, mem[4]=0x77.
REQ-040 Reset: assert reset with window=1 and mem non-zero -> next cycle all mem=0x00, window=0, cpu_rdata=0xFF.
